cdb_result_arbiter: RTL and testbench
=====================================

# cdb_result_arbiter

Round-robin arbiter that collects completed results from the functional units and drives one registered result per cycle onto the common data bus (CDB). Its packed output word (valid bit plus data) feeds the 33-bit enable-register wall that latches CDB results for the reservation stations and reorder buffer. The block also applies backpressure, so no result is lost when the consumer stalls.

## Interface

Parameters:
- DATA_WIDTH, 32, result data width.
- TAG_WIDTH, 5, ROB/physical tag width.
- NUM_SRC, 3, number of producing units. Index 0 is the ALU, 1 is the MUL, 2 is the LSU.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. reset=0 clears all state immediately.
- flush  input  1  synchronous mispredict flush.
- src_valid  input  NUM_SRC  per-unit result-valid.
- src_tag  input  NUM_SRC*TAG_WIDTH  per-unit tag. Unit i occupies slice [i*TAG_WIDTH +: TAG_WIDTH].
- src_data  input  NUM_SRC*DATA_WIDTH  per-unit data, sliced the same way.
- src_ready  output  NUM_SRC  per-unit grant. This output is combinational and is one-hot or zero.
- cdb_ready  input  1  consumer can accept the word this cycle. This signal drives the enable on the downstream register wall.
- cdb_valid  output  1  registered result-valid.
- cdb_tag  output  TAG_WIDTH  registered tag.
- cdb_data  output  DATA_WIDTH  registered data.
- cdb_word  output  DATA_WIDTH+1  the packed word {cdb_valid, cdb_data}, 33 bits at default width.

## Operation

- State:
  - Output register: cdb_valid, cdb_tag, cdb_data.
  - Round-robin pointer rr_ptr, width $clog2(NUM_SRC), holding values 0..NUM_SRC-1.
- Slot free: slot_free = !cdb_valid || cdb_ready.
- Arbitration, combinational:
  - Applies only when slot_free && !flush.
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC.
  - The first i with src_valid[i]=1 gets src_ready[i]=1. All other src_ready bits are 0.
  - If slot_free=0 or flush=1, all src_ready bits are 0.
- Transfer: a source transfer occurs when src_valid[i] && src_ready[i].
- Register update, in priority order:
  - reset=0 (asynchronous): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0.
  - flush=1: cdb_valid<=0. Tag and data are don't-care but hold. rr_ptr holds. No grant is issued.
  - Grant to i: cdb_valid<=1, cdb_tag<=src_tag slice i, cdb_data<=src_data slice i.
    - rr_ptr <= i+1, or 0 if i = NUM_SRC-1 (wrap-around).
  - slot_free with no requester: cdb_valid<=0, tag/data hold, rr_ptr holds.
  - Otherwise (cdb_valid=1 && cdb_ready=0, i.e. stall): all output registers hold unchanged.
- Sources must hold src_valid, tag and data stable until granted. The arbiter never drops a granted result.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 transfers before it is granted.

## Timing

- Latency: a grant in cycle N makes the result visible on cdb_* after edge N+1.
- Throughput: one result per cycle while cdb_ready=1.
- src_ready has a combinational path from src_valid, cdb_valid, cdb_ready, flush and rr_ptr. There is no path from src_ready back into src_valid.
- Consumption and refill in the same cycle: with cdb_valid=1 and cdb_ready=1, the consumer takes the current word and a new grant loads the register on the same edge. There is no bubble.
- Stall: while cdb_valid=1 and cdb_ready=0, the word holds indefinitely and src_ready=0.
- Flush in the same cycle as cdb_ready=1: the word is still consumed downstream, but the register clears to cdb_valid=0.
- Reset asserted mid-operation: outputs clear within the same cycle, without waiting for a clock edge. The first grant can occur in the first cycle after reset deasserts. rr_ptr=0 then favours the ALU.
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_word=0. src_ready=0 whenever src_valid=0.

## Test plan

- Reset check: hold reset=0 with random src_valid -> cdb_word=33'h0 and cdb_valid=0. After release, a first ALU request with tag 3 and data 0xDEADBEEF gives cdb_word=33'h1_DEADBEEF and cdb_tag=3 one cycle later.
- Round-robin order: all three src_valid=1 for 6 cycles, cdb_ready=1 -> src_ready sequence 001,010,100,001,010,100. cdb_tag follows the unit tags one cycle later. rr_ptr wraps 2 to 0.
- Backpressure: MUL granted with data 0x12345678, then cdb_ready=0 for 4 cycles -> cdb_data holds 0x12345678, cdb_valid=1, src_ready=0 throughout. When cdb_ready returns to 1, the next grant goes to the LSU.
- Fairness under a sparse pattern: LSU held valid, ALU toggling each cycle -> the LSU is granted within 2 transfers and never starved.
- Flush: flush=1 while cdb_valid=1 and all sources valid -> the next cycle gives cdb_valid=0, src_ready=0 during the flush cycle, and rr_ptr unchanged.
- Asynchronous reset mid-stream: pull reset low between clock edges during continuous traffic -> cdb_valid falls before the next edge. After release, grant order restarts at the ALU.

Source files
------------

// File: rtl/cdb_result_arbiter_if.sv
// Bundle between the functional units, the result arbiter and the CDB register wall.
// master is the arbiter side; slave is the producer/consumer environment.
interface cdb_result_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned NUM_SRC    = 3
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ready;

    logic                  cdb_ready;
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic [DATA_WIDTH:0]   cdb_word;

    modport master (
        input  src_valid, src_tag, src_data, cdb_ready,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_word
    );

    modport slave (
        output src_valid, src_tag, src_data, cdb_ready,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_word
    );
endinterface

// File: rtl/cdb_result_arbiter.sv
// Round-robin collector of functional-unit results onto a single registered CDB slot,
// with backpressure from the consumer and a synchronous mispredict flush.
module cdb_result_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned NUM_SRC    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    cdb_result_arbiter_if.master  bus
);
    localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  slot_free;
    logic                  grant_any;
    logic [PtrW-1:0]       grant_idx;
    logic [NUM_SRC-1:0]    grant;

    logic [TAG_WIDTH-1:0]  tag_arr  [NUM_SRC];
    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign tag_arr[g]  = bus.src_tag[g*TAG_WIDTH +: TAG_WIDTH];
        assign data_arr[g] = bus.src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // The slot can take a new word if empty or if its current word leaves this cycle.
    assign slot_free = !cdb_valid_q || bus.cdb_ready;

    // Scan from rr_ptr upward with wrap; first requester wins.
    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (slot_free && !flush) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!grant_any && bus.src_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = PtrW'(idx);
                end
            end
        end
    end

    assign grant = grant_any ? (NUM_SRC'(1) << grant_idx) : '0;

    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
        end else if (grant_any) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_arr[grant_idx];
            cdb_data_d  = data_arr[grant_idx];
            rr_ptr_d    = (grant_idx == PtrW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end else if (slot_free) begin
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.src_ready = grant;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_word  = {cdb_valid_q, cdb_data_q};

    a_ready_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(bus.src_ready));
    a_ready_needs_valid : assert property (@(posedge clk) disable iff (!reset)
        (bus.src_ready & ~bus.src_valid) == '0);
    a_ptr_range : assert property (@(posedge clk) disable iff (!reset)
        32'(rr_ptr_q) < NUM_SRC);
    // A stalled word must sit untouched until the consumer takes it.
    a_stall_hold : assert property (@(posedge clk) disable iff (!reset)
        (cdb_valid_q && !bus.cdb_ready && !flush) |=>
            (cdb_valid_q && $stable(cdb_tag_q) && $stable(cdb_data_q)));
endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Directed bench for cdb_result_arbiter: reset, round-robin order, backpressure,
// sparse fairness, flush and asynchronous mid-stream reset.
module tb_cdb_result_arbiter;
    logic clk;
    logic reset;
    logic flush;

    int unsigned n_checks;
    int unsigned n_bad;

    cdb_result_arbiter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5), .NUM_SRC(3)) bus ();

    cdb_result_arbiter #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (5),
        .NUM_SRC    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] t, input logic [31:0] d);
        bus.src_tag[i*5 +: 5]   = t;
        bus.src_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [2:0] exp_fair [4];
        int         lsu_wait;
        int         max_wait;
        n_checks = 0;
        n_bad    = 0;
        flush    = 1'b0;
        reset    = 1'b0;
        bus.src_valid = '0;
        bus.src_tag   = '0;
        bus.src_data  = '0;
        bus.cdb_ready = 1'b1;

        // Reset with random requests present.
        #2;
        bus.src_valid = 3'($urandom);
        #1;
        check("reset_word", 64'(bus.cdb_word), 64'h0);
        check("reset_valid", 64'(bus.cdb_valid), 64'h0);
        step();
        check("reset_word_edge", 64'(bus.cdb_word), 64'h0);

        reset = 1'b1;
        bus.src_valid = 3'b001;
        set_src(0, 5'd3, 32'hDEADBEEF);
        #1;
        check("first_ready", 64'(bus.src_ready), 64'h1);
        step();
        check("first_word", 64'(bus.cdb_word), 64'h1_DEADBEEF);
        check("first_tag", 64'(bus.cdb_tag), 64'h3);

        // Slot free, no requester: valid drops, data holds.
        bus.src_valid = 3'b000;
        #1;
        check("idle_ready", 64'(bus.src_ready), 64'h0);
        step();
        check("idle_valid", 64'(bus.cdb_valid), 64'h0);
        check("idle_data_hold", 64'(bus.cdb_data), 64'hDEADBEEF);

        // Round-robin with all units requesting.
        do_reset();
        set_src(0, 5'd10, 32'hA0A0_0000);
        set_src(1, 5'd11, 32'hB1B1_0001);
        set_src(2, 5'd12, 32'hC2C2_0002);
        bus.src_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_ready%0d", i), 64'(bus.src_ready), 64'(3'b001 << (i % 3)));
            step();
            check($sformatf("rr_tag%0d", i), 64'(bus.cdb_tag), 64'(10 + (i % 3)));
            check($sformatf("rr_valid%0d", i), 64'(bus.cdb_valid), 64'h1);
        end
        bus.src_valid = '0;

        // Backpressure: MUL granted, then consumer stalls with everyone requesting.
        do_reset();
        set_src(1, 5'd7, 32'h12345678);
        bus.src_valid = 3'b010;
        #1;
        check("bp_mul_ready", 64'(bus.src_ready), 64'h2);
        step();
        check("bp_mul_data", 64'(bus.cdb_data), 64'h12345678);
        set_src(1, 5'd8, 32'h87654321);
        set_src(2, 5'd9, 32'h0BADF00D);
        bus.src_valid = 3'b111;
        bus.cdb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 64'(bus.src_ready), 64'h0);
            step();
            check($sformatf("bp_data%0d", i), 64'(bus.cdb_data), 64'h12345678);
            check($sformatf("bp_valid%0d", i), 64'(bus.cdb_valid), 64'h1);
        end
        bus.cdb_ready = 1'b1;
        #1;
        check("bp_resume_ready", 64'(bus.src_ready), 64'h4);
        step();
        check("bp_resume_tag", 64'(bus.cdb_tag), 64'h9);
        bus.src_valid = '0;

        // Sparse fairness: LSU always valid, ALU toggling.
        do_reset();
        exp_fair[0] = 3'b001;
        exp_fair[1] = 3'b100;
        exp_fair[2] = 3'b001;
        exp_fair[3] = 3'b100;
        lsu_wait = 0;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            bus.src_valid = {1'b1, 1'b0, (i % 2 == 0)};
            #1;
            check($sformatf("fair_ready%0d", i), 64'(bus.src_ready), 64'(exp_fair[i]));
            if (bus.src_ready[2]) lsu_wait = 0;
            else if (bus.src_ready != 3'b000) lsu_wait++;
            if (lsu_wait > max_wait) max_wait = lsu_wait;
            step();
        end
        check("fair_lsu_bound", 64'(max_wait <= 2), 64'h1);
        bus.src_valid = '0;

        // Flush while a word is valid and every source requests.
        do_reset();
        bus.src_valid = 3'b111;
        step();
        check("fl_pre_valid", 64'(bus.cdb_valid), 64'h1);
        flush = 1'b1;
        #1;
        check("fl_ready", 64'(bus.src_ready), 64'h0);
        step();
        check("fl_valid", 64'(bus.cdb_valid), 64'h0);
        flush = 1'b0;
        #1;
        check("fl_ptr_hold", 64'(bus.src_ready), 64'h2);
        step();
        check("fl_after_tag", 64'(bus.cdb_tag), 64'h8);

        // Asynchronous reset between edges during continuous traffic.
        step();
        check("ar_pre_valid", 64'(bus.cdb_valid), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 64'(bus.cdb_valid), 64'h0);
        check("ar_word", 64'(bus.cdb_word), 64'h0);
        step();
        reset = 1'b1;
        #1;
        check("ar_restart_ready", 64'(bus.src_ready), 64'h1);
        step();
        check("ar_restart_tag", 64'(bus.cdb_tag), 64'hA);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
